// File: rtl/boot_loader.sv
`timescale 1ns/1ps
// boot_loader: after start_i, copies ROM_WORDS words from the boot ROM into RAM starting at RAM_BASE.
// Optional ROM-acknowledge watchdog is compiled in when BOOT_LOADER_TIMEOUT_EN is defined.
module boot_loader #(
    parameter int unsigned ROM_WORDS = 7,
    parameter logic [15:0] RAM_BASE  = 16'h0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start_i,
    output logic        rom_stb_o,
    input  logic        rom_ack_i,
    output logic [15:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic        ram_we_o,
    input  logic        ram_ack_i,
    output logic [15:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(ROM_WORDS - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] idx;
    logic [15:0] idx_next;
    logic [31:0] data_next;

`ifdef BOOT_LOADER_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt;
    logic [15:0] wait_next;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        data_next  = ram_data_o;
`ifdef BOOT_LOADER_TIMEOUT_EN
        // Counter is zero unless we stay in RD, so it clears on every entry to RD.
        wait_next  = '0;
`endif
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_next = RD;
                    idx_next   = '0;
                end
            end
            RD: begin
                if (rom_ack_i) begin
                    state_next = WR;
                    data_next  = rom_data_i;
                end
`ifdef BOOT_LOADER_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    state_next = ERR;
                end else begin
                    wait_next = wait_cnt + 16'd1;
                end
`endif
            end
            WR: begin
                if (ram_ack_i) begin
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        state_next = RD;
                        idx_next   = idx + 16'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus outputs are registered from the next-state values so they line up with the state they belong to.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            rom_stb_o  <= 1'b0;
            rom_addr_o <= '0;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            rom_stb_o  <= (state_next == RD);
            rom_addr_o <= idx_next;
            ram_we_o   <= (state_next == WR);
            ram_addr_o <= RAM_BASE + idx_next;
            ram_data_o <= data_next;
        end
    end

`ifdef BOOT_LOADER_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_next;
        end
    end

    assign err_o = (state == ERR);
`else
    assign err_o = 1'b0;
`endif

    assign busy_o = (state == RD) || (state == WR);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_boot_loader.sv
`timescale 1ns/1ps
// Directed bench for boot_loader: fast and stalled copies, address wrap, mid-copy reset, start handling.
module tb_boot_loader;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start_i;
    logic        rom_stb_o;
    logic        rom_ack_i;
    logic [15:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        ram_we_o;
    logic        ram_ack_i;
    logic [15:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    logic        w_start;
    logic        w_rom_stb;
    logic        w_rom_ack;
    logic [15:0] w_rom_addr;
    logic [31:0] w_rom_data;
    logic        w_ram_we;
    logic        w_ram_ack;
    logic [15:0] w_ram_addr;
    logic [31:0] w_ram_data;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    int vectors = 0;
    int errors  = 0;

    boot_loader #(.ROM_WORDS(7), .RAM_BASE(16'h0000), .TIMEOUT(10)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start_i   (start_i),
        .rom_stb_o (rom_stb_o),
        .rom_ack_i (rom_ack_i),
        .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i),
        .ram_we_o  (ram_we_o),
        .ram_ack_i (ram_ack_i),
        .ram_addr_o(ram_addr_o),
        .ram_data_o(ram_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    boot_loader #(.ROM_WORDS(4), .RAM_BASE(16'hFFFE), .TIMEOUT(255)) dut_wrap (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start_i   (w_start),
        .rom_stb_o (w_rom_stb),
        .rom_ack_i (w_rom_ack),
        .rom_addr_o(w_rom_addr),
        .rom_data_i(w_rom_data),
        .ram_we_o  (w_ram_we),
        .ram_ack_i (w_ram_ack),
        .ram_addr_o(w_ram_addr),
        .ram_data_o(w_ram_data),
        .busy_o    (w_busy),
        .done_o    (w_done),
        .err_o     (w_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        sys_rst_n  = 1'b0;
        start_i    = 1'b0;
        rom_ack_i  = 1'b0;
        ram_ack_i  = 1'b0;
        rom_data_i = '0;
        w_start    = 1'b0;
        w_rom_ack  = 1'b0;
        w_ram_ack  = 1'b0;
        w_rom_data = '0;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if ({rom_stb_o, rom_addr_o, ram_we_o, ram_addr_o, ram_data_o, busy_o, done_o, err_o} !== 69'd0) begin
            errors++;
            $display("FAIL reset_main: got %h required 0",
                     {rom_stb_o, rom_addr_o, ram_we_o, ram_addr_o, ram_data_o, busy_o, done_o, err_o});
        end
        vectors++;
        if ({w_rom_stb, w_rom_addr, w_ram_we, w_ram_addr, w_ram_data, w_busy, w_done, w_err} !== 69'd0) begin
            errors++;
            $display("FAIL reset_wrap: got %h required 0",
                     {w_rom_stb, w_rom_addr, w_ram_we, w_ram_addr, w_ram_data, w_busy, w_done, w_err});
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if ({rom_stb_o, ram_we_o, busy_o, done_o, err_o} !== 5'b00000) begin
            errors++;
            $display("FAIL idle_after_reset: stb/we/busy/done/err=%b required 00000",
                     {rom_stb_o, ram_we_o, busy_o, done_o, err_o});
        end
    endtask

    // ROM word i holds A000_0000+i; acks come after rom_lat/ram_lat extra stall cycles.
    task automatic test_copy(input int rom_lat, input int ram_lat, input int exp_done,
                             input bit poke, input string name);
        int w;
        int rd_wait;
        int wr_wait;
        int done_cyc;
        w        = 0;
        rd_wait  = 0;
        wr_wait  = 0;
        done_cyc = -1;
        @(negedge sys_clk);
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        vectors++;
        if ({busy_o, done_o, rom_stb_o, rom_addr_o} !== {3'b101, 16'h0000}) begin
            errors++;
            $display("FAIL %s_first_cycle: busy/done/stb=%b addr=%h required 101 addr=0000",
                     name, {busy_o, done_o, rom_stb_o}, rom_addr_o);
        end
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            rom_ack_i  = 1'b0;
            ram_ack_i  = 1'b0;
            rom_data_i = 32'hDEAD_BEEF;
            start_i    = poke && (cyc == 3 || cyc == 4);
            if (done_o === 1'b1) begin
                done_cyc = cyc;
            end else if (rom_stb_o === 1'b1) begin
                vectors++;
                if ({ram_we_o, rom_addr_o} !== {1'b0, 16'(w)}) begin
                    errors++;
                    $display("FAIL %s_rd cycle %0d: we=%b rom_addr=%h required we=0 rom_addr=%h",
                             name, cyc, ram_we_o, rom_addr_o, 16'(w));
                end
                if (rd_wait == rom_lat) begin
                    rom_ack_i  = 1'b1;
                    rom_data_i = 32'hA000_0000 + 32'(rom_addr_o);
                    rd_wait    = 0;
                end else begin
                    rd_wait++;
                end
            end else if (ram_we_o === 1'b1) begin
                vectors++;
                if ({ram_addr_o, ram_data_o} !== {16'(w), 32'hA000_0000 + 32'(w)}) begin
                    errors++;
                    $display("FAIL %s_wr cycle %0d: addr=%h data=%h required addr=%h data=%h",
                             name, cyc, ram_addr_o, ram_data_o, 16'(w), 32'hA000_0000 + 32'(w));
                end
                if (wr_wait == ram_lat) begin
                    ram_ack_i = 1'b1;
                    wr_wait   = 0;
                    w++;
                end else begin
                    wr_wait++;
                end
            end else begin
                vectors++;
                errors++;
                $display("FAIL %s_bubble cycle %0d: no request and not done", name, cyc);
            end
            if (done_cyc < 0) @(negedge sys_clk);
        end
        start_i   = 1'b0;
        rom_ack_i = 1'b0;
        ram_ack_i = 1'b0;
        vectors++;
        if (done_cyc != exp_done || w != 7) begin
            errors++;
            $display("FAIL %s_done: done cycle %0d words %0d required cycle %0d words 7",
                     name, done_cyc, w, exp_done);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            vectors++;
            if ({rom_stb_o, ram_we_o, busy_o, done_o, err_o} !== 5'b00010) begin
                errors++;
                $display("FAIL %s_after_done: stb/we/busy/done/err=%b required 00010",
                         name, {rom_stb_o, ram_we_o, busy_o, done_o, err_o});
            end
        end
    endtask

    task automatic test_wrap();
        int w;
        int done_cyc;
        logic [15:0] exp_addr;
        w        = 0;
        done_cyc = -1;
        @(negedge sys_clk);
        w_start = 1'b1;
        @(negedge sys_clk);
        w_start = 1'b0;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            w_rom_ack  = 1'b0;
            w_ram_ack  = 1'b0;
            w_rom_data = '0;
            if (w_done === 1'b1) begin
                done_cyc = cyc;
            end else if (w_rom_stb === 1'b1) begin
                w_rom_ack  = 1'b1;
                w_rom_data = 32'h5A00_0000 + 32'(w_rom_addr);
            end else if (w_ram_we === 1'b1) begin
                exp_addr = 16'hFFFE + 16'(w);
                vectors++;
                if ({w_ram_addr, w_ram_data} !== {exp_addr, 32'h5A00_0000 + 32'(w)}) begin
                    errors++;
                    $display("FAIL wrap_wr word %0d: addr=%h data=%h required addr=%h data=%h",
                             w, w_ram_addr, w_ram_data, exp_addr, 32'h5A00_0000 + 32'(w));
                end
                w_ram_ack = 1'b1;
                w++;
            end
            if (done_cyc < 0) @(negedge sys_clk);
        end
        w_rom_ack = 1'b0;
        w_ram_ack = 1'b0;
        vectors++;
        if (done_cyc != 9 || w != 4) begin
            errors++;
            $display("FAIL wrap_done: done cycle %0d words %0d required cycle 9 words 4", done_cyc, w);
        end
    endtask

    task automatic test_reset_mid_copy();
        bit hit;
        hit = 1'b0;
        @(negedge sys_clk);
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
            rom_ack_i = 1'b0;
            ram_ack_i = 1'b0;
            if (ram_we_o === 1'b1 && ram_addr_o === 16'd3) begin
                hit = 1'b1;
            end else begin
                if (rom_stb_o === 1'b1) begin
                    rom_ack_i  = 1'b1;
                    rom_data_i = 32'hA000_0000 + 32'(rom_addr_o);
                end
                if (ram_we_o === 1'b1) ram_ack_i = 1'b1;
                @(negedge sys_clk);
            end
        end
        vectors++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: write of word 3 not seen, got 0 required 1");
        end
        sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({rom_stb_o, rom_addr_o, ram_we_o, ram_addr_o, ram_data_o, busy_o, done_o, err_o} !== 69'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h required 0",
                     {rom_stb_o, rom_addr_o, ram_we_o, ram_addr_o, ram_data_o, busy_o, done_o, err_o});
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        vectors++;
        if ({rom_stb_o, ram_we_o, busy_o, done_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_idle: stb/we/busy/done=%b required 0000",
                     {rom_stb_o, ram_we_o, busy_o, done_o});
        end
        test_copy(0, 0, 15, 1'b0, "after_reset");
    endtask

`ifdef BOOT_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int rd_cycles;
        rd_cycles = 0;
        rom_ack_i = 1'b0;
        ram_ack_i = 1'b0;
        @(negedge sys_clk);
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        for (int c = 0; c < 40 && rom_stb_o === 1'b1; c++) begin
            rd_cycles++;
            @(negedge sys_clk);
        end
        vectors++;
        if (rd_cycles != 10) begin
            errors++;
            $display("FAIL timeout_rd_cycles: got %0d required 10", rd_cycles);
        end
        vectors++;
        if ({err_o, rom_stb_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_err: err/stb/busy=%b required 100", {err_o, rom_stb_o, busy_o});
        end
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        vectors++;
        if ({err_o, rom_stb_o, rom_addr_o} !== {2'b01, 16'h0000}) begin
            errors++;
            $display("FAIL timeout_restart: err/stb=%b addr=%h required 01 addr=0000",
                     {err_o, rom_stb_o}, rom_addr_o);
        end
        repeat (9) @(negedge sys_clk);
        rom_ack_i  = 1'b1;
        rom_data_i = 32'hA000_0000;
        @(negedge sys_clk);
        rom_ack_i = 1'b0;
        vectors++;
        if ({ram_we_o, rom_stb_o, err_o, ram_data_o} !== {3'b100, 32'hA000_0000}) begin
            errors++;
            $display("FAIL timeout_late_ack: we/stb/err=%b data=%h required 100 data=a0000000",
                     {ram_we_o, rom_stb_o, err_o}, ram_data_o);
        end
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask
`else
    task automatic test_no_timeout();
        rom_ack_i = 1'b0;
        ram_ack_i = 1'b0;
        @(negedge sys_clk);
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        repeat (300) @(negedge sys_clk);
        vectors++;
        if ({rom_stb_o, busy_o, err_o, rom_addr_o} !== {3'b110, 16'h0000}) begin
            errors++;
            $display("FAIL no_timeout_wait: stb/busy/err=%b addr=%h required 110 addr=0000",
                     {rom_stb_o, busy_o, err_o}, rom_addr_o);
        end
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask
`endif

    initial begin
        test_reset();
        test_copy(0, 0, 15, 1'b0, "copy_fast");
        test_copy(3, 2, 50, 1'b0, "copy_stall");
        test_copy(0, 0, 15, 1'b1, "busy_restart");
        test_wrap();
        test_reset_mid_copy();
`ifdef BOOT_LOADER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
